// File: rtl/bitbakery_serial_pkg.sv
// Shared definitions for the serial frame scheduler.
//   state_t   : scheduler FSM state encodings
//   CH_*      : channel indices (0 status, 1 move, 2 position, 3 obstacle map)
//   MAP_TAG   : upper tag bits of every obstacle-map byte
//   map_byte  : builds map byte k from a 16-bit map snapshot
package bitbakery_serial_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CARREGA = 2'd1,
        ENVIA   = 2'd2,
        ESPERA  = 2'd3
    } state_t;

    localparam logic [1:0] CH_STATUS = 2'd0;
    localparam logic [1:0] CH_MOVE   = 2'd1;
    localparam logic [1:0] CH_POS    = 2'd2;
    localparam logic [1:0] CH_MAP    = 2'd3;

    localparam logic [1:0] MAP_TAG   = 2'b11;

    // Byte k of the map frame: tag, byte index, then nibble k of the snapshot.
    function automatic logic [7:0] map_byte(input logic [15:0] snap, input logic [1:0] k);
        logic [3:0] nib;
        case (k)
            2'd0:    nib = snap[3:0];
            2'd1:    nib = snap[7:4];
            2'd2:    nib = snap[11:8];
            default: nib = snap[15:12];
        endcase
        return {MAP_TAG, k, nib};
    endfunction

endpackage

// File: rtl/contador_m.sv
// Free-running modulo-M counter.
//   clock    : rising-edge clock
//   reset_in : synchronous active-low clear
//   conta    : count enable
//   fim      : high during the last count (M-1), i.e. one cycle in every M
module contador_m #(
    parameter int M = 50
) (
    input  logic clock,
    input  logic reset_in,
    input  logic conta,
    output logic fim
);

    localparam int N = (M > 2) ? $clog2(M) : 1;

    logic [N-1:0] count_reg;

    assign fim = (count_reg == N'(M - 1));

    always_ff @(posedge clock) begin
        if (!reset_in) begin
            count_reg <= '0;
        end else if (conta) begin
            count_reg <= fim ? '0 : count_reg + 1'b1;
        end
    end

endmodule

// File: rtl/serial_frame_scheduler.sv
// Change-driven scheduler that feeds four telemetry channels to a UART.
// Each channel re-sends when its input differs from the last-sent snapshot
// or when the periodic refresh fires; channels are served round-robin.
//   clock, reset_in      : clock and synchronous active-low reset
//   habilita             : allows new channel grants
//   D0, D1, D2           : status / move / position bytes (1-byte frames)
//   map_obstacles        : 16-bit obstacle map (4-byte tagged frame)
//   tx_pronto            : byte-finished pulse from the UART
//   tx_partida, tx_dado  : start pulse and byte to the UART
//   ocupado, db_canal    : busy flag and current/last granted channel
module serial_frame_scheduler
    import bitbakery_serial_pkg::*;
#(
    parameter int REFRESH_CYCLES = 5000000
) (
    input  logic        clock,
    input  logic        reset_in,
    input  logic        habilita,
    input  logic [7:0]  D0,
    input  logic [7:0]  D1,
    input  logic [7:0]  D2,
    input  logic [15:0] map_obstacles,
    input  logic        tx_pronto,
    output logic        tx_partida,
    output logic [7:0]  tx_dado,
    output logic        ocupado,
    output logic [1:0]  db_canal
);

    state_t      state_reg, state_next;
    logic [3:0]  pending_reg, pending_next;
    logic [7:0]  snap_reg [3];
    logic [15:0] map_snap_reg;
    logic [1:0]  byte_idx_reg;
    logic [7:0]  data_in [3];
    logic [3:0]  diff;
    logic [3:0]  req;
    logic        tick;
    logic        grant_valid;
    logic [1:0]  grant_ch;
    logic        grant;
    logic [7:0]  load_byte;

    contador_m #(.M(REFRESH_CYCLES)) u_refresh (
        .clock    (clock),
        .reset_in (reset_in),
        .conta    (1'b1),
        .fim      (tick)
    );

    assign data_in[0] = D0;
    assign data_in[1] = D1;
    assign data_in[2] = D2;

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_byte_diff
            assign diff[gi] = (data_in[gi] != snap_reg[gi]);
        end
    endgenerate
    assign diff[3] = (map_obstacles != map_snap_reg);

    // A change seen this cycle can be granted immediately; the registered
    // pending bit remembers it for later cycles.
    assign req = pending_reg | diff;

    // Round-robin: look at last+1, last+2, last+3 and finally last itself.
    always_comb begin
        logic [1:0] cand;
        grant_valid = 1'b0;
        grant_ch    = db_canal;
        cand        = db_canal;
        for (int i = 1; i <= 4; i++) begin
            cand = db_canal + 2'(i);
            if (!grant_valid && req[cand]) begin
                grant_valid = 1'b1;
                grant_ch    = cand;
            end
        end
    end

    assign grant = (state_reg == IDLE) && habilita && grant_valid;

    // The granted channel clears, but a refresh in the same cycle wins so the
    // channel goes out again with the refreshed request.
    generate
        for (gi = 0; gi < 4; gi++) begin : g_pending
            assign pending_next[gi] = (grant && grant_ch == 2'(gi)) ? tick
                                    : (pending_reg[gi] | diff[gi] | tick);
        end
    endgenerate

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (grant) state_next = CARREGA;
            CARREGA: state_next = ENVIA;
            ENVIA:   state_next = ESPERA;
            ESPERA: begin
                if (tx_pronto) begin
                    if (db_canal == CH_MAP && byte_idx_reg != 2'd3) begin
                        state_next = CARREGA;
                    end else begin
                        state_next = IDLE;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        case (db_canal)
            CH_STATUS: load_byte = snap_reg[0];
            CH_MOVE:   load_byte = snap_reg[1];
            CH_POS:    load_byte = snap_reg[2];
            default:   load_byte = map_byte(map_snap_reg, byte_idx_reg);
        endcase
    end

    assign tx_partida = (state_reg == ENVIA);
    assign ocupado    = (state_reg != IDLE);

    always_ff @(posedge clock) begin
        if (!reset_in) begin
            state_reg    <= IDLE;
            pending_reg  <= 4'hF;
            map_snap_reg <= '0;
            byte_idx_reg <= '0;
            db_canal     <= CH_MAP;
            tx_dado      <= 8'h00;
            for (int i = 0; i < 3; i++) begin
                snap_reg[i] <= '0;
            end
        end else begin
            state_reg   <= state_next;
            pending_reg <= pending_next;
            if (grant) begin
                db_canal     <= grant_ch;
                byte_idx_reg <= '0;
                for (int i = 0; i < 3; i++) begin
                    if (grant_ch == 2'(i)) begin
                        snap_reg[i] <= data_in[i];
                    end
                end
                if (grant_ch == CH_MAP) begin
                    map_snap_reg <= map_obstacles;
                end
            end
            // tx_dado then holds through ENVIA and ESPERA.
            if (state_reg == CARREGA) begin
                tx_dado <= load_byte;
            end
            if (state_reg == ESPERA && tx_pronto) begin
                byte_idx_reg <= byte_idx_reg + 2'd1;
            end
        end
    end

endmodule

// File: tb/tb_serial_frame_scheduler.sv
module tb_serial_frame_scheduler;

    logic clock = 1'b0;
    always #10 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    int checks = 0;
    int failures = 0;

    // Main DUT: very long refresh so only changes trigger frames.
    logic        reset_in = 1'b0;
    logic        habilita = 1'b1;
    logic [7:0]  D0 = 8'h00, D1 = 8'h00, D2 = 8'h00;
    logic [15:0] map_obstacles = 16'h0000;
    logic        tx_pronto = 1'b0;
    logic        tx_partida;
    logic [7:0]  tx_dado;
    logic        ocupado;
    logic [1:0]  db_canal;

    serial_frame_scheduler #(.REFRESH_CYCLES(5000000)) dut (
        .clock(clock), .reset_in(reset_in), .habilita(habilita),
        .D0(D0), .D1(D1), .D2(D2), .map_obstacles(map_obstacles),
        .tx_pronto(tx_pronto), .tx_partida(tx_partida), .tx_dado(tx_dado),
        .ocupado(ocupado), .db_canal(db_canal)
    );

    // Second DUT: refresh every 50 cycles, constant inputs, fast UART.
    logic        r_reset_in = 1'b0;
    logic        r_habilita = 1'b1;
    logic [7:0]  r_D0 = 8'h01, r_D1 = 8'h02, r_D2 = 8'h03;
    logic [15:0] r_map = 16'h0000;
    logic        r_tx_pronto = 1'b0;
    logic        r_tx_partida;
    logic [7:0]  r_tx_dado;
    logic        r_ocupado;
    logic [1:0]  r_db_canal;

    serial_frame_scheduler #(.REFRESH_CYCLES(50)) dut_ref (
        .clock(clock), .reset_in(r_reset_in), .habilita(r_habilita),
        .D0(r_D0), .D1(r_D1), .D2(r_D2), .map_obstacles(r_map),
        .tx_pronto(r_tx_pronto), .tx_partida(r_tx_partida), .tx_dado(r_tx_dado),
        .ocupado(r_ocupado), .db_canal(r_db_canal)
    );

    // UART models: log every start, answer with tx_pronto N cycles later.
    logic [7:0] log_byte[$];
    int         log_cyc[$];
    logic [7:0] r_log_byte[$];
    int         r_log_cyc[$];
    int cnt = 0;
    int r_cnt = 0;

    always @(negedge clock) begin
        tx_pronto = 1'b0;
        if (cnt > 0) begin
            cnt = cnt - 1;
            if (cnt == 0) tx_pronto = 1'b1;
        end
        if (tx_partida === 1'b1) begin
            log_byte.push_back(tx_dado);
            log_cyc.push_back(cyc);
            $display("tx main cyc=%0d byte=%h ch=%0d", cyc, tx_dado, db_canal);
            cnt = 10;
        end
    end

    always @(negedge clock) begin
        r_tx_pronto = 1'b0;
        if (r_cnt > 0) begin
            r_cnt = r_cnt - 1;
            if (r_cnt == 0) r_tx_pronto = 1'b1;
        end
        if (r_tx_partida === 1'b1) begin
            r_log_byte.push_back(r_tx_dado);
            r_log_cyc.push_back(cyc);
            r_cnt = 1;
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic step();
        @(negedge clock);
        #1;
    endtask

    task automatic wait_count(input int n, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (log_byte.size() >= n) begin
                ok = 1'b1;
                break;
            end
            step();
        end
    endtask

    task automatic wait_idle(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (ocupado === 1'b0) begin
                ok = 1'b1;
                break;
            end
            step();
        end
    endtask

    int c0_main;
    int c0_ref;

    task automatic test_reset();
        reset_in = 1'b0;
        r_reset_in = 1'b0;
        habilita = 1'b1;
        D0 = 8'h05; D1 = 8'h41; D2 = 8'h83; map_obstacles = 16'hA5C3;
        repeat (3) step();
        checks++; if (tx_partida !== 1'b0) begin failures++; $display("FAIL reset_partida: got %b want 0", tx_partida); end
        checks++; if (tx_dado !== 8'h00) begin failures++; $display("FAIL reset_dado: got %h want 00", tx_dado); end
        checks++; if (ocupado !== 1'b0) begin failures++; $display("FAIL reset_ocupado: got %b want 0", ocupado); end
        checks++; if (db_canal !== 2'd3) begin failures++; $display("FAIL reset_canal: got %0d want 3", db_canal); end
        reset_in = 1'b1;
        r_reset_in = 1'b1;
        c0_main = cyc;
        c0_ref = cyc;
    endtask

    task automatic test_power_on_dump();
        logic [7:0] e[7] = '{8'h05, 8'h41, 8'h83, 8'hC3, 8'hDC, 8'hE5, 8'hFA};
        bit ok;
        wait_count(7, 300, ok);
        checks++; if (!ok) begin failures++; $display("FAIL dump_timeout: got %0d bytes want 7", log_byte.size()); end
        wait_idle(50, ok);
        checks++; if (!ok) begin failures++; $display("FAIL dump_idle: ocupado=%b want 0", ocupado); end
        checks++; if (log_cyc[0] !== c0_main + 2) begin failures++; $display("FAIL dump_latency: got cyc %0d want %0d", log_cyc[0], c0_main + 2); end
        for (int i = 0; i < 7; i++) begin
            checks++;
            if (log_byte[i] !== e[i]) begin failures++; $display("FAIL dump_byte%0d: got %h want %h", i, log_byte[i], e[i]); end
        end
    endtask

    task automatic test_single_change();
        bit ok;
        int base;
        int c;
        base = log_byte.size();
        step();
        D1 = 8'h47;
        c = cyc;
        wait_count(base + 1, 20, ok);
        checks++; if (!ok) begin failures++; $display("FAIL single_timeout: got %0d bytes want %0d", log_byte.size(), base + 1); end
        checks++; if (log_byte[base] !== 8'h47) begin failures++; $display("FAIL single_byte: got %h want 47", log_byte[base]); end
        checks++; if (log_cyc[base] !== c + 2) begin failures++; $display("FAIL single_latency: got cyc %0d want %0d", log_cyc[base], c + 2); end
        wait_idle(50, ok);
        repeat (30) step();
        checks++; if (log_byte.size() !== base + 1) begin failures++; $display("FAIL single_extra: got %0d bytes want %0d", log_byte.size(), base + 1); end
    endtask

    task automatic test_round_robin();
        logic [7:0] e[9] = '{8'hC4, 8'hD3, 8'hE2, 8'hF1, 8'h11, 8'h22, 8'h33, 8'h55, 8'h44};
        bit ok, all_ok;
        int base;
        all_ok = 1'b1;
        base = log_byte.size();
        step(); map_obstacles = 16'h1234;
        wait_count(base + 4, 100, ok); all_ok &= ok;
        wait_idle(50, ok); all_ok &= ok;
        checks++; if (db_canal !== 2'd3) begin failures++; $display("FAIL rr_last3: got %0d want 3", db_canal); end
        step(); D0 = 8'h11; D2 = 8'h22;
        wait_count(base + 6, 100, ok); all_ok &= ok;
        wait_idle(50, ok); all_ok &= ok;
        step(); D0 = 8'h33;
        wait_count(base + 7, 50, ok); all_ok &= ok;
        wait_idle(50, ok); all_ok &= ok;
        checks++; if (db_canal !== 2'd0) begin failures++; $display("FAIL rr_last0: got %0d want 0", db_canal); end
        step(); D0 = 8'h44; D2 = 8'h55;
        wait_count(base + 9, 100, ok); all_ok &= ok;
        wait_idle(50, ok); all_ok &= ok;
        checks++; if (!all_ok) begin failures++; $display("FAIL rr_timeout: got %0d bytes want %0d", log_byte.size() - base, 9); end
        for (int i = 0; i < 9; i++) begin
            checks++;
            if (log_byte[base + i] !== e[i]) begin failures++; $display("FAIL rr_byte%0d: got %h want %h", i, log_byte[base + i], e[i]); end
        end
    endtask

    task automatic test_inflight_change();
        bit ok, ok2;
        int base;
        base = log_byte.size();
        step(); D2 = 8'h83;
        wait_count(base + 1, 20, ok);
        repeat (3) step();
        D2 = 8'h8F;
        step();
        checks++; if (tx_dado !== 8'h83) begin failures++; $display("FAIL inflight_hold: got %h want 83", tx_dado); end
        checks++; if (ocupado !== 1'b1) begin failures++; $display("FAIL inflight_busy: got %b want 1", ocupado); end
        wait_count(base + 2, 60, ok2);
        checks++; if (!(ok && ok2)) begin failures++; $display("FAIL inflight_timeout: got %0d bytes want 2", log_byte.size() - base); end
        wait_idle(50, ok);
        checks++; if (log_byte[base] !== 8'h83) begin failures++; $display("FAIL inflight_first: got %h want 83", log_byte[base]); end
        checks++; if (log_byte[base + 1] !== 8'h8F) begin failures++; $display("FAIL inflight_second: got %h want 8F", log_byte[base + 1]); end
    endtask

    task automatic test_habilita_drop();
        bit ok, ok2;
        int base;
        int c;
        base = log_byte.size();
        step(); map_obstacles = 16'hA5C3;
        wait_count(base + 2, 60, ok);
        habilita = 1'b0;
        D0 = 8'h66;
        wait_count(base + 4, 80, ok2);
        checks++; if (!(ok && ok2)) begin failures++; $display("FAIL hab_timeout: got %0d bytes want 4", log_byte.size() - base); end
        wait_idle(50, ok);
        repeat (40) step();
        checks++; if (log_byte.size() !== base + 4) begin failures++; $display("FAIL hab_blocked: got %0d bytes want %0d", log_byte.size(), base + 4); end
        checks++; if (ocupado !== 1'b0) begin failures++; $display("FAIL hab_idle: got %b want 0", ocupado); end
        checks++; if (log_byte[base + 2] !== 8'hE5) begin failures++; $display("FAIL hab_byte2: got %h want E5", log_byte[base + 2]); end
        checks++; if (log_byte[base + 3] !== 8'hFA) begin failures++; $display("FAIL hab_byte3: got %h want FA", log_byte[base + 3]); end
        habilita = 1'b1;
        c = cyc;
        wait_count(base + 5, 10, ok);
        checks++; if (log_byte[base + 4] !== 8'h66) begin failures++; $display("FAIL hab_resume: got %h want 66", log_byte[base + 4]); end
        checks++; if (log_cyc[base + 4] !== c + 2) begin failures++; $display("FAIL hab_latency: got cyc %0d want %0d", log_cyc[base + 4], c + 2); end
        wait_idle(50, ok);
    endtask

    task automatic test_reset_midframe();
        logic [7:0] e[7] = '{8'h66, 8'h99, 8'h8F, 8'hC3, 8'hDC, 8'hE5, 8'hFA};
        bit ok;
        int base;
        int c;
        base = log_byte.size();
        step(); D1 = 8'h99;
        wait_count(base + 1, 20, ok);
        repeat (3) step();
        reset_in = 1'b0;
        step();
        checks++; if (ocupado !== 1'b0) begin failures++; $display("FAIL rst_mid_ocupado: got %b want 0", ocupado); end
        checks++; if (tx_partida !== 1'b0) begin failures++; $display("FAIL rst_mid_partida: got %b want 0", tx_partida); end
        checks++; if (db_canal !== 2'd3) begin failures++; $display("FAIL rst_mid_canal: got %0d want 3", db_canal); end
        repeat (11) step();
        checks++; if (log_byte.size() !== base + 1) begin failures++; $display("FAIL rst_mid_quiet: got %0d bytes want %0d", log_byte.size(), base + 1); end
        reset_in = 1'b1;
        c = cyc;
        wait_count(base + 8, 300, ok);
        checks++; if (!ok) begin failures++; $display("FAIL rst_redump_timeout: got %0d bytes want 7", log_byte.size() - base - 1); end
        checks++; if (log_cyc[base + 1] !== c + 2) begin failures++; $display("FAIL rst_redump_latency: got cyc %0d want %0d", log_cyc[base + 1], c + 2); end
        for (int i = 0; i < 7; i++) begin
            checks++;
            if (log_byte[base + 1 + i] !== e[i]) begin failures++; $display("FAIL rst_redump_byte%0d: got %h want %h", i, log_byte[base + 1 + i], e[i]); end
        end
        wait_idle(50, ok);
    endtask

    task automatic test_refresh();
        logic [7:0] e[7] = '{8'h01, 8'h02, 8'h03, 8'hC0, 8'hD0, 8'hE0, 8'hF0};
        checks++; if (r_log_byte.size() < 21) begin failures++; $display("FAIL refresh_count: got %0d bytes want >=21", r_log_byte.size()); end
        checks++; if (r_log_cyc[0] !== c0_ref + 2) begin failures++; $display("FAIL refresh_first: got cyc %0d want %0d", r_log_cyc[0], c0_ref + 2); end
        for (int d = 0; d < 2; d++) begin
            checks++;
            if (r_log_cyc[7 * (d + 1)] - r_log_cyc[7 * d] !== 50) begin
                failures++;
                $display("FAIL refresh_period%0d: got %0d want 50", d, r_log_cyc[7 * (d + 1)] - r_log_cyc[7 * d]);
            end
        end
        for (int d = 0; d < 3; d++) begin
            for (int i = 0; i < 7; i++) begin
                checks++;
                if (r_log_byte[7 * d + i] !== e[i]) begin
                    failures++;
                    $display("FAIL refresh_dump%0d_byte%0d: got %h want %h", d, i, r_log_byte[7 * d + i], e[i]);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_power_on_dump();
        test_single_change();
        test_round_robin();
        test_inflight_change();
        test_habilita_drop();
        test_reset_midframe();
        test_refresh();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
